// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-indexed data memory that only has full-word writes.
// Sub-word loads are extracted and extended here; sub-word stores become a read-modify-write.
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RMW   = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic [31:0] wdata_r;
    logic [31:0] merge_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic        req_err_s;
    logic        accept_s;

    // Misaligned, illegal-funct3 and out-of-range all collapse into one error bit.
    function automatic logic check_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'd0:    bad = 1'b0;
            3'd1:    bad = addr[0];
            3'd2:    bad = |addr[1:0];
            3'd4:    bad = we;
            3'd5:    bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        if (addr[31:2] >= MEM_LIMIT) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane, input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    res = {{24{b[7]}}, b};
            3'd1:    res = {{16{h[15]}}, h};
            3'd2:    res = word;
            3'd4:    res = {24'h000000, b};
            3'd5:    res = {16'h0000, h};
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] res;
        res = word;
        if (f3 == 3'd0) begin
            case (lane)
                2'd0:    res[7:0]   = wd[7:0];
                2'd1:    res[15:8]  = wd[7:0];
                2'd2:    res[23:16] = wd[7:0];
                2'd3:    res[31:24] = wd[7:0];
                default: res = word;
            endcase
        end else if (f3 == 3'd1) begin
            if (lane[1]) begin
                res[31:16] = wd[15:0];
            end else begin
                res[15:0] = wd[15:0];
            end
        end else begin
            res = word;
        end
        return res;
    endfunction

    assign req_err_s  = check_err(req_we, req_funct3, req_addr);
    assign req_ready  = (state_r == ST_IDLE);
    assign accept_s   = req_valid && req_ready;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    // Write enable is gated by RST so an abandoned store can never reach memory.
    assign mem_we     = RST && (state_r == ST_WRITE);
    assign mem_a      = {2'b00, addr_r[31:2]};
    assign mem_wd     = (funct3_r == 3'd2) ? wdata_r : merge_r;

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_err_s) begin
                        state_next_s = ST_RESP;
                    end else if (!req_we) begin
                        state_next_s = ST_LOAD;
                    end else if (req_funct3 == 3'd2) begin
                        state_next_s = ST_WRITE;
                    end else begin
                        state_next_s = ST_RMW;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_next_s = ST_RESP;
            ST_RMW:   state_next_s = ST_WRITE;
            ST_WRITE: state_next_s = ST_RESP;
            ST_RESP:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register, request latch, merge buffer and registered response.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r      <= ST_IDLE;
            addr_r       <= 32'h00000000;
            funct3_r     <= 3'd0;
            wdata_r      <= 32'h00000000;
            merge_r      <= 32'h00000000;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h00000000;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            resp_valid_r <= (state_next_s == ST_RESP);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r       <= req_addr;
                        funct3_r     <= req_funct3;
                        wdata_r      <= req_wdata;
                        merge_r      <= 32'h00000000;
                        resp_rdata_r <= 32'h00000000;
                        resp_err_r   <= req_err_s;
                    end
                end
                ST_LOAD: resp_rdata_r <= extract(mem_rd, addr_r[1:0], funct3_r);
                ST_RMW:  merge_r      <= merge(mem_rd, addr_r[1:0], funct3_r, wdata_r);
                default: resp_rdata_r <= resp_rdata_r;
            endcase
        end
    end

endmodule
